// File: rtl/axil_conv_mem_bridge_if.sv
// rtl/axil_conv_mem_bridge_if.sv - AXI4-Lite slave bundle for the conv memory bridge
interface axil_conv_mem_bridge_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32
) ();
  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr;
  logic                      s_axi_awvalid;
  logic                      s_axi_awready;
  logic [DATA_WIDTH-1:0]     s_axi_wdata;
  logic [3:0]                s_axi_wstrb;
  logic                      s_axi_wvalid;
  logic                      s_axi_wready;
  logic [1:0]                s_axi_bresp;
  logic                      s_axi_bvalid;
  logic                      s_axi_bready;
  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr;
  logic                      s_axi_arvalid;
  logic                      s_axi_arready;
  logic [DATA_WIDTH-1:0]     s_axi_rdata;
  logic [1:0]                s_axi_rresp;
  logic                      s_axi_rvalid;
  logic                      s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axil_conv_mem_bridge.sv
// rtl/axil_conv_mem_bridge.sv - AXI4-Lite slave driving conv memory single-cycle strobes
// Optional byte-strobe read-modify-write enabled by defining AXIL_BRIDGE_STRB_EN.
module axil_conv_mem_bridge #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int VALID_ADDR_WIDTH = 14,
  parameter int DATA_WIDTH       = 32,
  parameter int READ_LATENCY     = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  axil_conv_mem_bridge_if.slave       s_axi,
  output logic                        o_we,
  output logic                        o_re,
  output logic [VALID_ADDR_WIDTH-1:0] o_write_addr,
  output logic [VALID_ADDR_WIDTH-1:0] o_read_addr,
  output logic [DATA_WIDTH-1:0]       o_data,
  input  logic [DATA_WIDTH-1:0]       i_data
);
  localparam int             CW          = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0]  CNT_LAST    = CW'(READ_LATENCY - 1);
  localparam logic [1:0]     RESP_OKAY   = 2'b00;
  localparam logic [1:0]     RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_BRESP,
    S_RD,
    S_RWAIT,
`ifdef AXIL_BRIDGE_STRB_EN
    S_WR_RD,
    S_WR_RWAIT,
`endif
    S_RRESP
  } state_t;

  state_t                      r_state, w_next;
  logic                        r_prefer_wr;
  logic                        r_wr_ok, r_rd_ok;
  logic [1:0]                  r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0]       r_rdata;
  logic [CW-1:0]               r_cnt;

  logic                        w_wr_pend, w_rd_pend, w_grant_wr, w_grant_rd;
  logic                        w_aw_ok, w_ar_ok, w_wr_touch, w_cnt_last;
  logic [VALID_ADDR_WIDTH-1:0] w_aw_word, w_ar_word;
  logic                        w_awready, w_arready, w_bvalid, w_rvalid, w_we, w_re;

  assign w_aw_ok    = ~|s_axi.s_axi_awaddr[AXI_ADDR_WIDTH-1:VALID_ADDR_WIDTH+2];
  assign w_ar_ok    = ~|s_axi.s_axi_araddr[AXI_ADDR_WIDTH-1:VALID_ADDR_WIDTH+2];
  assign w_aw_word  = s_axi.s_axi_awaddr[VALID_ADDR_WIDTH+1:2];
  assign w_ar_word  = s_axi.s_axi_araddr[VALID_ADDR_WIDTH+1:2];
  assign w_wr_pend  = s_axi.s_axi_awvalid && s_axi.s_axi_wvalid;
  assign w_rd_pend  = s_axi.s_axi_arvalid;
  // Round-robin only matters when both sides are pending in the same IDLE cycle.
  assign w_grant_wr = w_wr_pend && (!w_rd_pend || r_prefer_wr);
  assign w_grant_rd = w_rd_pend && !w_grant_wr;
  assign w_cnt_last = (r_cnt == CNT_LAST);

`ifdef AXIL_BRIDGE_STRB_EN
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_wstrb;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_partial, w_zero;
  logic                  w_unused_bits;

  assign w_zero        = (s_axi.s_axi_wstrb == 4'h0);
  assign w_partial     = w_aw_ok && !w_zero && (s_axi.s_axi_wstrb != 4'hF);
  assign w_wr_touch    = w_aw_ok && !w_zero;
  assign w_unused_bits = ^{s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

  always_comb begin
    w_merged = i_data;
    for (int b = 0; b < 4; b++) begin
      if (r_wstrb[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
    end
  end
`else
  logic w_unused_bits;
  assign w_wr_touch    = w_aw_ok;
  assign w_unused_bits = ^{s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0], s_axi.s_axi_wstrb};
`endif

  always_comb begin
    w_next    = r_state;
    w_awready = 1'b0;
    w_arready = 1'b0;
    w_bvalid  = 1'b0;
    w_rvalid  = 1'b0;
    w_we      = 1'b0;
    w_re      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_wr) begin
          w_awready = 1'b1;
          w_next    = S_WR;
`ifdef AXIL_BRIDGE_STRB_EN
          if (w_aw_ok && w_zero) w_next = S_BRESP;
          else if (w_partial)    w_next = S_WR_RD;
`endif
        end else if (w_grant_rd) begin
          w_arready = 1'b1;
          w_next    = S_RD;
        end
      end
      S_WR: begin
        w_we   = r_wr_ok;
        w_next = S_BRESP;
      end
      S_BRESP: begin
        w_bvalid = 1'b1;
        if (s_axi.s_axi_bready) w_next = S_IDLE;
      end
      S_RD: begin
        w_re   = r_rd_ok;
        w_next = S_RWAIT;
      end
      S_RWAIT: begin
        if (w_cnt_last) w_next = S_RRESP;
      end
      S_RRESP: begin
        w_rvalid = 1'b1;
        if (s_axi.s_axi_rready) w_next = S_IDLE;
      end
`ifdef AXIL_BRIDGE_STRB_EN
      S_WR_RD: begin
        w_re   = 1'b1;
        w_next = S_WR_RWAIT;
      end
      S_WR_RWAIT: begin
        if (w_cnt_last) w_next = S_WR;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_prefer_wr  <= 1'b1;
      r_wr_ok      <= 1'b0;
      r_rd_ok      <= 1'b0;
      r_bresp      <= RESP_OKAY;
      r_rresp      <= RESP_OKAY;
      r_rdata      <= '0;
      r_cnt        <= '0;
      o_write_addr <= '0;
      o_read_addr  <= '0;
      o_data       <= '0;
`ifdef AXIL_BRIDGE_STRB_EN
      r_wdata      <= '0;
      r_wstrb      <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_grant_wr) begin
        r_prefer_wr <= 1'b0;
        r_wr_ok     <= w_aw_ok;
        r_bresp     <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
        // Downstream address/data only move when a strobe will follow.
        if (w_wr_touch) begin
          o_write_addr <= w_aw_word;
          o_data       <= s_axi.s_axi_wdata;
        end
`ifdef AXIL_BRIDGE_STRB_EN
        r_wdata <= s_axi.s_axi_wdata;
        r_wstrb <= s_axi.s_axi_wstrb;
        if (w_partial) o_read_addr <= w_aw_word;
`endif
      end else if (r_state == S_IDLE && w_grant_rd) begin
        r_prefer_wr <= 1'b1;
        r_rd_ok     <= w_ar_ok;
        r_rresp     <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
        if (w_ar_ok) o_read_addr <= w_ar_word;
      end
      if (r_state == S_RWAIT) begin
        r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
        if (w_cnt_last) r_rdata <= r_rd_ok ? i_data : '0;
      end
`ifdef AXIL_BRIDGE_STRB_EN
      if (r_state == S_WR_RWAIT) begin
        r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
        if (w_cnt_last) o_data <= w_merged;
      end
`endif
    end
  end

  assign s_axi.s_axi_awready = w_awready;
  assign s_axi.s_axi_wready  = w_awready;
  assign s_axi.s_axi_arready = w_arready;
  assign s_axi.s_axi_bvalid  = w_bvalid;
  assign s_axi.s_axi_bresp   = r_bresp;
  assign s_axi.s_axi_rvalid  = w_rvalid;
  assign s_axi.s_axi_rresp   = r_rresp;
  assign s_axi.s_axi_rdata   = r_rdata;
  assign o_we                = w_we;
  assign o_re                = w_re;
endmodule

// File: tb/tb_axil_conv_mem_bridge.sv
// tb/tb_axil_conv_mem_bridge.sv - scoreboard bench for axil_conv_mem_bridge
module tb_axil_conv_mem_bridge;
  logic        clk;
  logic        rst_n;
  logic        o_we, o_re;
  logic [13:0] o_write_addr, o_read_addr;
  logic [31:0] o_data, i_data;
  logic [31:0] mem [0:16383];
  int          total, bad;

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [31:0] data;
  } ds_t;

  ds_t         ds_q [$];
  logic [1:0]  b_q  [$];
  logic [33:0] r_q  [$];

  axil_conv_mem_bridge_if #(.AXI_ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_conv_mem_bridge #(
    .AXI_ADDR_WIDTH(32), .VALID_ADDR_WIDTH(14), .DATA_WIDTH(32), .READ_LATENCY(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .s_axi(bus),
    .o_we(o_we), .o_re(o_re), .o_write_addr(o_write_addr), .o_read_addr(o_read_addr),
    .o_data(o_data), .i_data(i_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem[14'h0000] <= 32'hCAFE0000;
      mem[14'h3FFF] <= 32'h00000001;
      mem[14'h00D9] <= 32'h5555AAAA;
      mem[14'h0010] <= 32'h12345678;
    end else begin
      if (o_re) i_data <= mem[o_read_addr];
      if (o_we) mem[o_write_addr] <= o_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_we || o_re) begin
        if (ds_q.size() == 0) check("ds_unexpected", 32'({o_we, o_re}), 32'h0);
        else begin
          ds_t e;
          e = ds_q.pop_front();
          check("ds_kind", 32'(o_we), 32'(e.we));
          check("ds_addr", 32'(o_we ? o_write_addr : o_read_addr), 32'(e.addr));
          if (e.we) check("ds_data", o_data, e.data);
        end
      end
      if (bus.s_axi_bvalid && bus.s_axi_bready) begin
        if (b_q.size() == 0) check("b_unexpected", 32'h1, 32'h0);
        else check("bresp", 32'(bus.s_axi_bresp), 32'(b_q.pop_front()));
      end
      if (bus.s_axi_rvalid && bus.s_axi_rready) begin
        if (r_q.size() == 0) check("r_unexpected", 32'h1, 32'h0);
        else begin
          logic [33:0] e;
          e = r_q.pop_front();
          check("rresp", 32'(bus.s_axi_rresp), 32'(e[33:32]));
          check("rdata", bus.s_axi_rdata, e[31:0]);
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] resp, input logic exp_we, input int bdelay);
    int n;
    b_q.push_back(resp);
    @(posedge clk); #1;
    bus.s_axi_awaddr = addr; bus.s_axi_wdata = data; bus.s_axi_wstrb = strb;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(bus.s_axi_awready && bus.s_axi_wready) && n < 50);
    check("aw_accept", 32'(bus.s_axi_awready && bus.s_axi_wready), 32'h1);
    @(posedge clk); #1;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    @(negedge clk);
    check("we_latency", 32'(o_we), 32'(exp_we));
    n = 0;
    while (!bus.s_axi_bvalid && n < 20) begin @(negedge clk); n++; end
    check("bvalid_seen", 32'(bus.s_axi_bvalid), 32'h1);
    for (int i = 0; i < bdelay; i++) begin
      @(posedge clk); @(negedge clk);
      check("bvalid_hold", 32'(bus.s_axi_bvalid), 32'h1);
    end
    @(posedge clk); #1 bus.s_axi_bready = 1'b1;
    @(posedge clk); #1 bus.s_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] resp,
                         input logic exp_re, input int rdelay);
    int n;
    r_q.push_back({resp, exp_data});
    @(posedge clk); #1;
    bus.s_axi_araddr = addr; bus.s_axi_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.s_axi_arready && n < 50);
    check("ar_accept", 32'(bus.s_axi_arready), 32'h1);
    @(posedge clk); #1 bus.s_axi_arvalid = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) check("re_latency", 32'(o_re), 32'(exp_re));
    end while (!bus.s_axi_rvalid && n < 20);
    check("rvalid_latency", 32'(n), 32'd3);
    for (int i = 0; i < rdelay; i++) begin
      @(posedge clk); @(negedge clk);
      check("rvalid_hold", 32'(bus.s_axi_rvalid), 32'h1);
    end
    @(posedge clk); #1 bus.s_axi_rready = 1'b1;
    @(posedge clk); #1 bus.s_axi_rready = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0;
    bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0; bus.s_axi_araddr = '0;
    bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}), 32'h0);
    check("rst_valid", 32'({bus.s_axi_bvalid, bus.s_axi_rvalid, o_we, o_re}), 32'h0);
    check("rst_addr", 32'({o_write_addr, o_read_addr}), 32'h0);
    check("rst_data", o_data | bus.s_axi_rdata, 32'h0);
    check("rst_resp", 32'({bus.s_axi_bresp, bus.s_axi_rresp}), 32'h0);
    rst_n = 1'b1;

    // reset lands while a read of word 2 sits in RWAIT
    ds_q.push_back('{we: 1'b0, addr: 14'h0002, data: 32'h0});
    @(posedge clk); #1;
    bus.s_axi_araddr = 32'h8; bus.s_axi_arvalid = 1'b1;
    @(negedge clk);
    check("mid_ar_accept", 32'(bus.s_axi_arready), 32'h1);
    @(posedge clk); #1 bus.s_axi_arvalid = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b0; #1;
    check("mid_rst_out", 32'({bus.s_axi_rvalid, bus.s_axi_arready, o_re}), 32'h0);
    check("mid_rst_raddr", 32'(o_read_addr), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ds_q.push_back('{we: 1'b0, addr: 14'h0000, data: 32'h0});
    do_read(32'h0, 32'hCAFE0000, 2'b00, 1'b1, 0);

    ds_q.push_back('{we: 1'b1, addr: 14'h0001, data: 32'h9ABCDEF0});
    do_write(32'h0004, 32'h9ABCDEF0, 4'hF, 2'b00, 1'b1, 3);

    ds_q.push_back('{we: 1'b0, addr: 14'h3FFF, data: 32'h0});
    do_read(32'hFFFC, 32'h00000001, 2'b00, 1'b1, 2);

    for (int k = 0; k < 2; k++) begin
      ds_q.push_back('{we: 1'b1, addr: 14'h00D8, data: 32'h22222222});
      ds_q.push_back('{we: 1'b0, addr: 14'h00D9, data: 32'h0});
      fork
        do_write(32'h0360, 32'h22222222, 4'hF, 2'b00, 1'b1, 0);
        do_read(32'h0364, 32'h5555AAAA, 2'b00, 1'b1, 0);
      join
    end

    do_write(32'h0001_0000, 32'h11111111, 4'hF, 2'b10, 1'b0, 0);
    do_read(32'h0002_0000, 32'h0, 2'b10, 1'b0, 0);

`ifdef AXIL_BRIDGE_STRB_EN
    ds_q.push_back('{we: 1'b0, addr: 14'h0010, data: 32'h0});
    ds_q.push_back('{we: 1'b1, addr: 14'h0010, data: 32'h12BB56DD});
    do_write(32'h0040, 32'hAABBCCDD, 4'b0101, 2'b00, 1'b0, 0);
    do_write(32'h0040, 32'hFFFFFFFF, 4'h0, 2'b00, 1'b0, 0);
    ds_q.push_back('{we: 1'b0, addr: 14'h0010, data: 32'h0});
    do_read(32'h0040, 32'h12BB56DD, 2'b00, 1'b1, 0);
`else
    ds_q.push_back('{we: 1'b1, addr: 14'h0011, data: 32'hAABBCCDD});
    do_write(32'h0044, 32'hAABBCCDD, 4'b0101, 2'b00, 1'b1, 0);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("ds_q_empty", 32'(ds_q.size()), 32'h0);
    check("b_q_empty", 32'(b_q.size()), 32'h0);
    check("r_q_empty", 32'(r_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
